// File: rtl/logic_unit_stage.sv
// logic_unit_stage: registered WIDTH-bit AND/OR/XOR/NOT unit with valid/ready
// handshakes on both sides, a two-entry (main + skid) output buffer, ZERO and
// PARITY flags derived from OUT, and a saturating count of output transfers.
module logic_unit_stage #(
    parameter int WIDTH = 8,
    parameter int CW    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [1:0]       OP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             ZERO,
    output logic             PARITY,
    input  logic             CLR_COUNT,
    output logic [CW-1:0]    DONE_COUNT
);

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    logic             r_mv;
    logic [WIDTH-1:0] r_md;
    logic             r_sv;
    logic [WIDTH-1:0] r_sd;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_result;
    logic             w_accept;
    logic             w_xfer;
    op_e              w_op;

    assign w_op     = op_e'(OP);
    assign w_accept = IN_VALID && IN_READY;
    assign w_xfer   = r_mv && OUT_READY;

    // Per-bit logic cell: each result bit depends only on X[i], Y[i] and OP
    always_comb begin
        w_result = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            unique case (w_op)
                OP_AND:  w_result[i] = X[i] & Y[i];
                OP_OR:   w_result[i] = X[i] | Y[i];
                OP_XOR:  w_result[i] = X[i] ^ Y[i];
                default: w_result[i] = ~X[i];
            endcase
        end
    end

    // Main/skid buffer update; skid only fills while main is stalled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mv <= 1'b0;
            r_md <= '0;
            r_sv <= 1'b0;
            r_sd <= '0;
        end else if (!r_mv) begin
            if (w_accept) begin
                r_mv <= 1'b1;
                r_md <= w_result;
            end
        end else if (w_xfer) begin
            if (r_sv) begin
                r_md <= r_sd;
                r_sv <= 1'b0;
            end else if (w_accept) begin
                r_md <= w_result;
            end else begin
                r_mv <= 1'b0;
            end
        end else if (w_accept) begin
            r_sd <= w_result;
            r_sv <= 1'b1;
        end
    end

    // Saturating transfer counter; clear takes priority over a same-edge transfer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (CLR_COUNT) begin
            r_cnt <= '0;
        end else if (w_xfer && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Ready depends only on the skid register and reset, never on OUT_READY
    always_comb begin
        IN_READY   = !RST && !r_sv;
        OUT_VALID  = r_mv;
        OUT        = r_md;
        ZERO       = ~|r_md;
        PARITY     = ^r_md;
        DONE_COUNT = r_cnt;
    end

endmodule
